// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: sequencing controller for the mm:ss BCD digit counter.
// RUN mode produces a one-cycle tick_en every TICK_DIV cycles. SET_MIN and
// SET_SEC freeze ticking so the user can edit minutes and then seconds with
// the inc button. Leaving SET_SEC pulses load with the edited time.
// Optional macro CLOCK_SET_BLINK_EN adds a blink phase that drives
// blank_min / blank_sec while a field is being edited.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_sec_r,
  input  logic [2:0] cur_sec_l,
  input  logic [3:0] cur_min_r,
  input  logic [2:0] cur_min_l,
  output logic       tick_en,
  output logic       load,
  output logic [3:0] ld_sec_r,
  output logic [2:0] ld_sec_l,
  output logic [3:0] ld_min_r,
  output logic [2:0] ld_min_l,
  output logic [1:0] mode,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam int unsigned    PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_MIN = 2'b01,
    ST_SET_SEC = 2'b10
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_tick_en;
  logic          r_load;
  logic          r_mode_prev;
  logic          r_inc_prev;
  logic [3:0]    r_min_r;
  logic [2:0]    r_min_l;
  logic [3:0]    r_sec_r;
  logic [2:0]    r_sec_l;

  logic          w_mode_press;
  logic          w_inc_press;
  logic [3:0]    w_min_r_clamp;
  logic [2:0]    w_min_l_clamp;
  logic [3:0]    w_sec_r_clamp;
  logic [2:0]    w_sec_l_clamp;
  logic [3:0]    w_min_r_inc;
  logic [2:0]    w_min_l_inc;
  logic [3:0]    w_sec_r_inc;
  logic [2:0]    w_sec_l_inc;

  // Rising-edge press detection against the previous button level
  assign w_mode_press = mode_btn & ~r_mode_prev;
  assign w_inc_press  = inc_btn  & ~r_inc_prev;

  // Previous button levels; reset high so a button held through reset is not a press
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
    end else begin
      r_mode_prev <= mode_btn;
      r_inc_prev  <= inc_btn;
    end
  end

  // BCD +1 for both fields; out-of-range digits clamp to 9 / 5 so they wrap to 0
  always_comb begin
    w_min_r_clamp = (r_min_r > 4'd9) ? 4'd9 : r_min_r;
    w_min_l_clamp = (r_min_l > 3'd5) ? 3'd5 : r_min_l;
    w_sec_r_clamp = (r_sec_r > 4'd9) ? 4'd9 : r_sec_r;
    w_sec_l_clamp = (r_sec_l > 3'd5) ? 3'd5 : r_sec_l;

    w_min_r_inc = w_min_r_clamp + 4'd1;
    w_min_l_inc = w_min_l_clamp;
    if (w_min_r_clamp == 4'd9) begin
      w_min_r_inc = 4'd0;
      w_min_l_inc = (w_min_l_clamp == 3'd5) ? 3'd0 : w_min_l_clamp + 3'd1;
    end

    w_sec_r_inc = w_sec_r_clamp + 4'd1;
    w_sec_l_inc = w_sec_l_clamp;
    if (w_sec_r_clamp == 4'd9) begin
      w_sec_r_inc = 4'd0;
      w_sec_l_inc = (w_sec_l_clamp == 3'd5) ? 3'd0 : w_sec_l_clamp + 3'd1;
    end
  end

  // Mode FSM with prescaler, edit registers and registered strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_presc   <= '0;
      r_tick_en <= 1'b0;
      r_load    <= 1'b0;
      r_min_r   <= 4'd0;
      r_min_l   <= 3'd0;
      r_sec_r   <= 4'd0;
      r_sec_l   <= 3'd0;
    end else begin
      r_tick_en <= 1'b0;
      r_load    <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_mode_press) begin
            r_min_r <= cur_min_r;
            r_min_l <= cur_min_l;
            r_sec_r <= cur_sec_r;
            r_sec_l <= cur_sec_l;
            r_presc <= '0;
            r_state <= ST_SET_MIN;
          end else if (r_presc == TICK_LAST) begin
            r_presc   <= '0;
            r_tick_en <= 1'b1;
          end else begin
            r_presc <= r_presc + PRESC_ONE;
          end
        end
        ST_SET_MIN: begin
          r_presc <= '0;
          if (w_mode_press) begin
            r_state <= ST_SET_SEC;
          end else if (w_inc_press) begin
            r_min_r <= w_min_r_inc;
            r_min_l <= w_min_l_inc;
          end
        end
        ST_SET_SEC: begin
          r_presc <= '0;
          if (w_mode_press) begin
            r_load  <= 1'b1;
            r_state <= ST_RUN;
          end else if (w_inc_press) begin
            r_sec_r <= w_sec_r_inc;
            r_sec_l <= w_sec_l_inc;
          end
        end
        default: begin
          r_presc <= '0;
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign tick_en  = r_tick_en;
  assign load     = r_load;
  assign mode     = r_state;
  assign ld_min_r = r_min_r;
  assign ld_min_l = r_min_l;
  assign ld_sec_r = r_sec_r;
  assign ld_sec_l = r_sec_l;

`ifdef CLOCK_SET_BLINK_EN
  localparam int unsigned   BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          r_blank_min;
  logic          r_blank_sec;

  // Blink phase: restarts on entering a set mode or on any inc press, idle in RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_blank_min <= 1'b0;
      r_blank_sec <= 1'b0;
    end else begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_blank_min <= 1'b0;
      r_blank_sec <= 1'b0;
      if ((r_state == ST_SET_MIN || r_state == ST_SET_SEC) &&
          !w_mode_press && !w_inc_press) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_phase     <= ~r_phase;
          r_blank_min <= (r_state == ST_SET_MIN) & ~r_phase;
          r_blank_sec <= (r_state == ST_SET_SEC) & ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_ONE;
          r_phase     <= r_phase;
          r_blank_min <= (r_state == ST_SET_MIN) & r_phase;
          r_blank_sec <= (r_state == ST_SET_SEC) & r_phase;
        end
      end
    end
  end

  assign blank_min = r_blank_min;
  assign blank_sec = r_blank_sec;
`else
  // Blink hardware is not built; BLINK_DIV is kept only for a uniform interface
  logic w_unused_blink_div;
  assign w_unused_blink_div = (BLINK_DIV > 0);
  assign blank_min = 1'b0;
  assign blank_sec = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with TICK_DIV=4, BLINK_DIV=3.
module tb_clock_set_ctrl;
  localparam int TD = 4;
  localparam int BD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_btn = 1'b1;
  logic       inc_btn = 1'b0;
  logic [3:0] cur_sec_r = 4'd0;
  logic [2:0] cur_sec_l = 3'd0;
  logic [3:0] cur_min_r = 4'd0;
  logic [2:0] cur_min_l = 3'd0;
  logic       tick_en, load, blank_min, blank_sec;
  logic [3:0] ld_sec_r, ld_min_r;
  logic [2:0] ld_sec_l, ld_min_l;
  logic [1:0] mode;

  clock_set_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_sec_r(cur_sec_r), .cur_sec_l(cur_sec_l),
    .cur_min_r(cur_min_r), .cur_min_l(cur_min_l),
    .tick_en(tick_en), .load(load),
    .ld_sec_r(ld_sec_r), .ld_sec_l(ld_sec_l),
    .ld_min_r(ld_min_r), .ld_min_l(ld_min_l),
    .mode(mode), .blank_min(blank_min), .blank_sec(blank_sec)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time as decimal numbers, tick as elapsed RUN cycles
  int m_mode, m_min_l, m_min_r, m_sec_l, m_sec_r, m_cnt, m_blink;
  bit m_prev_mode, m_prev_inc, e_tick, e_load;

  wire [19:0] dut_vec = {tick_en, load, mode, ld_min_l, ld_min_r,
                         ld_sec_l, ld_sec_r, blank_min, blank_sec};

  function automatic void bump(inout int l, inout int r);
    int v;
    v = (((l > 5) ? 5 : l) * 10 + ((r > 9) ? 9 : r) + 1) % 60;
    l = v / 10;
    r = v % 10;
  endfunction

  function automatic void model_edge();
    bit mp, ip;
    if (!rst) begin
      m_mode = 0; m_min_l = 0; m_min_r = 0; m_sec_l = 0; m_sec_r = 0;
      m_cnt = 0; m_blink = 0; m_prev_mode = 1; m_prev_inc = 1;
      e_tick = 0; e_load = 0;
      return;
    end
    mp = mode_btn && !m_prev_mode;
    ip = inc_btn && !m_prev_inc;
    m_prev_mode = mode_btn;
    m_prev_inc = inc_btn;
    e_tick = 0;
    e_load = 0;
    case (m_mode)
      0: if (mp) begin
           m_min_l = int'(cur_min_l); m_min_r = int'(cur_min_r);
           m_sec_l = int'(cur_sec_l); m_sec_r = int'(cur_sec_r);
           m_mode = 1; m_blink = 0;
         end else begin
           m_cnt++;
           e_tick = (m_cnt % TD == 0);
         end
      1: if (mp) begin m_mode = 2; m_blink = 0; end
         else if (ip) begin bump(m_min_l, m_min_r); m_blink = 0; end
         else m_blink++;
      default: if (mp) begin m_mode = 0; e_load = 1; m_cnt = 0; end
         else if (ip) begin bump(m_sec_l, m_sec_r); m_blink = 0; end
         else m_blink++;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec();
    logic bm, bs;
    bm = 1'b0;
    bs = 1'b0;
`ifdef CLOCK_SET_BLINK_EN
    bm = (m_mode == 1) && ((m_blink / BD) % 2 == 1);
    bs = (m_mode == 2) && ((m_blink / BD) % 2 == 1);
`endif
    return {e_tick, e_load, 2'(m_mode), 3'(m_min_l), 4'(m_min_r),
            3'(m_sec_l), 4'(m_sec_r), bm, bs};
  endfunction

  task automatic step(input logic mb, input logic ib, input logic rb);
    mode_btn = mb;
    inc_btn = ib;
    rst = rb;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_cur(input int mm, input int ss);
    cur_min_l = 3'(mm / 10); cur_min_r = 4'(mm % 10);
    cur_sec_l = 3'(ss / 10); cur_sec_r = 4'(ss % 10);
  endtask

  task automatic test_reset();
    int ticks;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({mode, tick_en, load, ld_min_l, ld_min_r, ld_sec_l, ld_sec_r, blank_min, blank_sec} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", dut_vec);
    end
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_run cycle %0d: got %h required %h", i, dut_vec, exp_vec());
      end
      checks++;
      if (tick_en !== (i % 4 == 0) || mode !== 2'b00 || load !== 1'b0) begin
        errors++;
        $display("FAIL reset_tick cycle %0d: tick=%b mode=%b load=%b required tick=%0d mode=00 load=0",
                 i, tick_en, mode, load, (i % 4 == 0));
      end
      if (tick_en === 1'b1) ticks++;
    end
    $display("test_reset: %0d ticks in 12 cycles with mode held", ticks);
  endtask

  task automatic test_edit();
    logic [1:0] seq [21] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                             2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01,
                             2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    int loads, load_idx, tick_idx;
    loads = 0; load_idx = -1; tick_idx = -1;
    set_cur(12, 34);
    for (int i = 0; i < 21; i++) begin
      step(seq[i][1], seq[i][0], 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL edit step %0d: got %h required %h", i, dut_vec, exp_vec());
      end
      if ((i == 1 && mode !== 2'b01) || (i == 9 && mode !== 2'b10) || (i == 15 && mode !== 2'b00)) begin
        errors++;
        $display("FAIL edit_mode step %0d: got %b", i, mode);
      end
      if (i == 1 || i == 9 || i == 15) checks++;
      if (load === 1'b1) begin
        loads++;
        load_idx = i;
        checks++;
        if ({ld_min_l, ld_min_r, ld_sec_l, ld_sec_r} !== {3'd1, 4'd5, 3'd3, 4'd6}) begin
          errors++;
          $display("FAIL edit_load_value: got %0d%0d:%0d%0d required 15:36", ld_min_l, ld_min_r, ld_sec_l, ld_sec_r);
        end
        $display("test_edit: load at step %0d ld=%0d%0d:%0d%0d", i, ld_min_l, ld_min_r, ld_sec_l, ld_sec_r);
      end
      if (tick_en === 1'b1 && load_idx >= 0 && tick_idx < 0) tick_idx = i;
    end
    checks++;
    if (loads != 1 || tick_idx - load_idx != 4) begin
      errors++;
      $display("FAIL edit_load_tick: loads=%0d gap=%0d required loads=1 gap=4", loads, tick_idx - load_idx);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] seq [15] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01,
                             2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    set_cur(59, 59);
    for (int i = 0; i < 15; i++) begin
      step(seq[i][1], seq[i][0], 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL wrap step %0d: got %h required %h", i, dut_vec, exp_vec());
      end
      if (i == 3) begin
        checks++;
        if ({ld_min_l, ld_min_r, ld_sec_l, ld_sec_r} !== {3'd0, 4'd0, 3'd5, 4'd9}) begin
          errors++;
          $display("FAIL wrap_min: got %0d%0d:%0d%0d required 00:59", ld_min_l, ld_min_r, ld_sec_l, ld_sec_r);
        end
      end
      if (i == 9) begin
        checks++;
        if (load !== 1'b1 || {ld_min_l, ld_min_r, ld_sec_l, ld_sec_r} !== 14'd0) begin
          errors++;
          $display("FAIL wrap_load: load=%b ld=%0d%0d:%0d%0d required load=1 00:00", load, ld_min_l, ld_min_r, ld_sec_l, ld_sec_r);
        end
        $display("test_wrap: load at step %0d ld=%0d%0d:%0d%0d", i, ld_min_l, ld_min_r, ld_sec_l, ld_sec_r);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] seq [10] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00,
                             2'b10, 2'b00, 2'b00};
    set_cur(7, 21);
    for (int i = 0; i < 10; i++) begin
      step(seq[i][1], seq[i][0], 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL simul step %0d: got %h required %h", i, dut_vec, exp_vec());
      end
      if (i == 5) begin
        checks++;
        if (mode !== 2'b10 || {ld_min_l, ld_min_r} !== {3'd0, 4'd8}) begin
          errors++;
          $display("FAIL simul_mode_wins: mode=%b min=%0d%0d required mode=10 min=08", mode, ld_min_l, ld_min_r);
        end
      end
    end
    $display("test_simultaneous: mode+inc press handled");
  endtask

  task automatic test_reset_mid();
    logic [1:0] seq [7] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    set_cur(30, 45);
    for (int i = 0; i < 7; i++) begin
      step(seq[i][1], seq[i][0], 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_pre step %0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (mode !== 2'b00 || load !== 1'b0 || {ld_min_l, ld_min_r, ld_sec_l, ld_sec_r} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_state: mode=%b load=%b ld=%h required 00 0 0", mode, load, {ld_min_l, ld_min_r, ld_sec_l, ld_sec_r});
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (tick_en !== (i == 4) || load !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_tick cycle %0d: tick=%b load=%b required tick=%0d load=0", i, tick_en, load, (i == 4));
      end
    end
    $display("test_reset_mid: edits discarded, prescaler restarted");
  endtask

`ifdef CLOCK_SET_BLINK_EN
  task automatic test_blink();
    set_cur(10, 10);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (blank_min !== ((k / 3) % 2 == 1) || blank_sec !== 1'b0) begin
        errors++;
        $display("FAIL blink_toggle k=%0d: blank_min=%b blank_sec=%b required %0d 0", k, blank_min, blank_sec, (k / 3) % 2);
      end
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (blank_min !== 1'b0) begin
      errors++;
      $display("FAIL blink_inc_show: blank_min=%b required 0", blank_min);
    end
    step(1'b0, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (blank_min !== 1'b0 || blank_sec !== 1'b0 || mode !== 2'b00) begin
        errors++;
        $display("FAIL blink_run k=%0d: blank_min=%b blank_sec=%b mode=%b required 0 0 00", k, blank_min, blank_sec, mode);
      end
    end
    $display("test_blink: blink phase checked");
  endtask
`endif

  task automatic test_random();
    int loads;
    loads = 0;
    for (int i = 0; i < 3000; i++) begin
      cur_min_l = 3'($urandom_range(0, 7));
      cur_min_r = 4'($urandom_range(0, 15));
      cur_sec_l = 3'($urandom_range(0, 7));
      cur_sec_r = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0), ($urandom_range(0, 299) != 0));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h required %h", i, dut_vec, exp_vec());
      end
      checks++;
      if (tick_en === 1'b1 && load === 1'b1) begin
        errors++;
        $display("FAIL random_tick_load_overlap cycle %0d: tick=1 load=1 required not both", i);
      end
      if (load === 1'b1) loads++;
    end
    $display("test_random: 3000 cycles, %0d loads", loads);
  endtask

  initial begin
    test_reset();
    test_edit();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
`ifdef CLOCK_SET_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
